// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
//
// Registered, handshaked writeback stage for the NPC core. It accepts one
// retiring instruction from MEM. A load waits here for its memory response,
// and the stage then aligns the load data and sign- or zero-extends it. The
// stage selects one of four writeback sources and drives the register-file
// write port together with a one-cycle commit pulse.
//
// Optional feature (compile-time macro WRITEBACK_MEM_TIMEOUT_EN):
//   A watchdog on WAIT_MEM. After TIMEOUT_CYCLES response-less cycles it
//   raises mem_timeout for one cycle and commits the load with data 0.
//   Without the macro, mem_timeout is tied to 0 and a load waits forever.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   in_valid/in_ready  upstream handshake (in_ready low only in WAIT_MEM)
//   in_alu_result      ALU result, also the load byte address
//   in_snpc            static next PC
//   in_csr_rdata       CSR read data
//   in_wbsel           0 ALU, 1 SNPC, 2 MEM, 3 CSR
//   in_rd, in_wen      destination register and its write enable
//   in_is_load         entry must wait for mem_rvalid
//   in_funct3          load type
//   in_pc              instruction PC
//   mem_rvalid         one-cycle load data valid pulse
//   mem_rdata          raw aligned word/doubleword
//   rf_wen/rf_waddr/rf_wdata  register-file write port (valid in COMMIT)
//   commit_valid/commit_pc    retirement pulse and its PC
//   mem_timeout        watchdog pulse (0 without the optional feature)
// -----------------------------------------------------------------------------
module writeback_stage #(
  parameter int XLEN           = 32,
  parameter int REG_AW         = 5,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_alu_result,
  input  logic [XLEN-1:0]   in_snpc,
  input  logic [XLEN-1:0]   in_csr_rdata,
  input  logic [1:0]        in_wbsel,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_wen,
  input  logic              in_is_load,
  input  logic [2:0]        in_funct3,
  input  logic [XLEN-1:0]   in_pc,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              rf_wen,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              commit_valid,
  output logic [XLEN-1:0]   commit_pc,
  output logic              mem_timeout
);

  // Byte-offset width inside one memory beat: 2 for RV32, 3 for RV64.
  localparam int OFFW = $clog2(XLEN / 8);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    COMMIT   = 2'd2
  } state_t;

  state_t state_reg;

  // Entry fields that are latched on accept.
  logic [XLEN-1:0]   alu_reg;
  logic [XLEN-1:0]   snpc_reg;
  logic [XLEN-1:0]   csr_reg;
  logic [XLEN-1:0]   pc_reg;
  logic [1:0]        wbsel_reg;
  logic [REG_AW-1:0] rd_reg;
  logic              wen_reg;
  logic [2:0]        funct3_reg;

  // Registered outputs.
  logic              in_ready_reg;
  logic              rf_wen_reg;
  logic [REG_AW-1:0] rf_waddr_reg;
  logic [XLEN-1:0]   rf_wdata_reg;
  logic              commit_valid_reg;
  logic [XLEN-1:0]   commit_pc_reg;

  logic accept;
  assign accept = in_valid && in_ready_reg;

  // ---------------------------------------------------------------------------
  // Load extraction. This uses the latched address and funct3. It is only
  // meaningful in WAIT_MEM, which is the only state that consumes it.
  // ---------------------------------------------------------------------------
  logic [OFFW-1:0] off;
  logic [OFFW-1:0] off_h;
  logic [OFFW-1:0] off_w;
  logic [7:0]      byte_val;
  logic [15:0]     half_val;
  logic [31:0]     word_val;
  logic [XLEN-1:0] word_sext;
  logic [XLEN-1:0] word_zext;
  logic [XLEN-1:0] load_ext;

  always_comb begin
    off   = alu_reg[OFFW-1:0];
    // Halfword and word accesses ignore the low offset bits.
    off_h = off & ~OFFW'(1);
    off_w = off & ~OFFW'(3);
    byte_val = 8'(mem_rdata >> {off, 3'b000});
    half_val = 16'(mem_rdata >> {off_h, 3'b000});
    word_val = 32'(mem_rdata >> {off_w, 3'b000});
  end

  generate
    if (XLEN == 64) begin : g_rv64_word
      assign word_sext = {{32{word_val[31]}}, word_val};
      assign word_zext = {32'b0, word_val};
    end else begin : g_rv32_word
      // A word is the full beat on RV32. LWU does not exist there, so it
      // takes the raw-data path.
      assign word_sext = word_val;
      assign word_zext = mem_rdata;
    end
  endgenerate

  always_comb begin
    case (funct3_reg)
      3'b000:  load_ext = {{(XLEN-8){byte_val[7]}}, byte_val};
      3'b100:  load_ext = {{(XLEN-8){1'b0}}, byte_val};
      3'b001:  load_ext = {{(XLEN-16){half_val[15]}}, half_val};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, half_val};
      3'b010:  load_ext = word_sext;
      3'b110:  load_ext = word_zext;
      // LD is the raw beat on RV64. On RV32 it falls into the raw path too.
      default: load_ext = mem_rdata;
    endcase
  end

  function automatic logic [XLEN-1:0] wb_select(
    input logic [1:0]      sel,
    input logic [XLEN-1:0] alu_v,
    input logic [XLEN-1:0] snpc_v,
    input logic [XLEN-1:0] load_v,
    input logic [XLEN-1:0] csr_v
  );
    case (sel)
      2'd0:    return alu_v;
      2'd1:    return snpc_v;
      2'd2:    return load_v;
      default: return csr_v;
    endcase
  endfunction

`ifdef WRITEBACK_MEM_TIMEOUT_EN
  // Counter width tracks TIMEOUT_CYCLES and is clamped to 8..32 bits.
  localparam int TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TW     = (TW_RAW < 8) ? 8 : ((TW_RAW > 32) ? 32 : TW_RAW);

  logic [TW-1:0] tmo_cnt_reg;
  logic          mem_timeout_reg;
  logic          tmo_hit;

  // This compares against TIMEOUT_CYCLES-1 because the check happens on the
  // response-less cycle whose increment would take the count to the limit.
  assign tmo_hit = (tmo_cnt_reg == TW'(TIMEOUT_CYCLES - 1));
`endif

  // ---------------------------------------------------------------------------
  // FSM and registered outputs. The commit outputs are loaded on the edge that
  // enters COMMIT and are cleared on every other edge. This makes them a
  // single-cycle pulse with zeroed data outside COMMIT.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      alu_reg          <= '0;
      snpc_reg         <= '0;
      csr_reg          <= '0;
      pc_reg           <= '0;
      wbsel_reg        <= '0;
      rd_reg           <= '0;
      wen_reg          <= 1'b0;
      funct3_reg       <= '0;
      in_ready_reg     <= 1'b1;
      rf_wen_reg       <= 1'b0;
      rf_waddr_reg     <= '0;
      rf_wdata_reg     <= '0;
      commit_valid_reg <= 1'b0;
      commit_pc_reg    <= '0;
`ifdef WRITEBACK_MEM_TIMEOUT_EN
      tmo_cnt_reg      <= '0;
      mem_timeout_reg  <= 1'b0;
`endif
    end else begin
      rf_wen_reg       <= 1'b0;
      rf_waddr_reg     <= '0;
      rf_wdata_reg     <= '0;
      commit_valid_reg <= 1'b0;
      commit_pc_reg    <= '0;
`ifdef WRITEBACK_MEM_TIMEOUT_EN
      mem_timeout_reg  <= 1'b0;
`endif

      case (state_reg)
        IDLE, COMMIT: begin
          if (accept) begin
            alu_reg    <= in_alu_result;
            snpc_reg   <= in_snpc;
            csr_reg    <= in_csr_rdata;
            pc_reg     <= in_pc;
            wbsel_reg  <= in_wbsel;
            rd_reg     <= in_rd;
            wen_reg    <= in_wen;
            funct3_reg <= in_funct3;
            if (in_is_load) begin
              state_reg    <= WAIT_MEM;
              in_ready_reg <= 1'b0;
`ifdef WRITEBACK_MEM_TIMEOUT_EN
              tmo_cnt_reg  <= '0;
`endif
            end else begin
              // A non-load commits straight from the incoming fields. A MEM
              // select without a load has no data, so it writes 0.
              state_reg        <= COMMIT;
              in_ready_reg     <= 1'b1;
              commit_valid_reg <= 1'b1;
              commit_pc_reg    <= in_pc;
              rf_wen_reg       <= in_wen && (in_rd != '0);
              rf_waddr_reg     <= in_rd;
              rf_wdata_reg     <= wb_select(in_wbsel, in_alu_result, in_snpc,
                                            '0, in_csr_rdata);
            end
          end else begin
            state_reg    <= IDLE;
            in_ready_reg <= 1'b1;
          end
        end

        WAIT_MEM: begin
          if (mem_rvalid) begin
            state_reg        <= COMMIT;
            in_ready_reg     <= 1'b1;
            commit_valid_reg <= 1'b1;
            commit_pc_reg    <= pc_reg;
            rf_wen_reg       <= wen_reg && (rd_reg != '0);
            rf_waddr_reg     <= rd_reg;
            rf_wdata_reg     <= wb_select(wbsel_reg, alu_reg, snpc_reg,
                                          load_ext, csr_reg);
          end
`ifdef WRITEBACK_MEM_TIMEOUT_EN
          else if (tmo_hit) begin
            state_reg        <= COMMIT;
            in_ready_reg     <= 1'b1;
            mem_timeout_reg  <= 1'b1;
            commit_valid_reg <= 1'b1;
            commit_pc_reg    <= pc_reg;
            rf_wen_reg       <= wen_reg && (rd_reg != '0);
            rf_waddr_reg     <= rd_reg;
            rf_wdata_reg     <= wb_select(wbsel_reg, alu_reg, snpc_reg,
                                          '0, csr_reg);
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
`endif
        end

        default: begin
          state_reg    <= IDLE;
          in_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_reg;
  assign rf_wen       = rf_wen_reg;
  assign rf_waddr     = rf_waddr_reg;
  assign rf_wdata     = rf_wdata_reg;
  assign commit_valid = commit_valid_reg;
  assign commit_pc    = commit_pc_reg;

`ifdef WRITEBACK_MEM_TIMEOUT_EN
  assign mem_timeout = mem_timeout_reg;
`else
  assign mem_timeout = 1'b0;
`endif

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Registered, handshaked writeback stage for the NPC core.
- Successor to the combinational writeback mux. Accepts one retiring instruction from MEM and, for loads, waits for a multi-cycle memory response.
- Aligns and sign- or zero-extends load data, selects among four writeback sources, and drives the register-file write port plus a one-cycle commit pulse.
- Sits between the memory-access stage and the regfile/difftest commit logic.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- REG_AW, 5, register address width.
- TIMEOUT_CYCLES, 255, WAIT_MEM watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept an entry this cycle
- in_alu_result  in  XLEN  ALU result; also the load address
- in_snpc  in  XLEN  static next PC
- in_csr_rdata  in  XLEN  CSR read data
- in_wbsel  in  2  source select: 0 ALU, 1 SNPC, 2 MEM, 3 CSR
- in_rd  in  REG_AW  destination register
- in_wen  in  1  instruction writes rd
- in_is_load  in  1  entry must wait for mem_rvalid
- in_funct3  in  3  load type
- in_pc  in  XLEN  instruction PC, for commit
- mem_rvalid  in  1  load data valid, one-cycle pulse
- mem_rdata  in  XLEN  raw aligned-word/doubleword read data
- rf_wen  out  1  regfile write enable
- rf_waddr  out  REG_AW  regfile write address
- rf_wdata  out  XLEN  regfile write data
- commit_valid  out  1  instruction retired this cycle
- commit_pc  out  XLEN  PC of retired instruction
- mem_timeout  out  1  watchdog fired; tied 0 when the optional feature is absent

Behaviour:
- FSM states: IDLE, WAIT_MEM, COMMIT. Reset state IDLE.
- Reset values: all outputs 0 except in_ready = 1. All latched entry fields are cleared to 0.
- in_ready = 1 in IDLE and COMMIT, and 0 in WAIT_MEM.
- Accept: in_valid && in_ready. Latch all in_* fields.
  - Next state is WAIT_MEM if in_is_load, otherwise COMMIT.
- WAIT_MEM:
  - On mem_rvalid, latch the extracted load data and go to COMMIT.
  - Otherwise hold.
  - mem_rvalid is ignored in IDLE and COMMIT.
- COMMIT (exactly one cycle):
  - commit_valid = 1 and commit_pc = latched pc.
  - rf_wen = latched wen && (rd != 0); rf_waddr = latched rd.
  - A new accept in the same cycle is permitted. With no accept, next state is IDLE.
- Latency and throughput:
  - Non-load: commit on the cycle after accept; back-to-back throughput is 1 per cycle.
  - Load: commit on the cycle after mem_rvalid.
- rf_wdata in COMMIT, selected by wbsel:
  - 0: ALU result.
  - 1: snpc.
  - 2: extracted load data.
  - 3: csr_rdata.
- Outside COMMIT: rf_wen = 0, commit_valid = 0, and rf_wdata / rf_waddr / commit_pc = 0.
- Load extraction uses off = alu_result[log2(XLEN/8)-1:0] as a byte offset into mem_rdata.
  - funct3 000 LB: byte at off, sign-extended.
  - funct3 100 LBU: byte at off, zero-extended.
  - funct3 001 LH / 101 LHU: halfword at off with off[0] ignored; LH sign-extends, LHU zero-extends.
  - funct3 010 LW: word at off with off[1:0] ignored; sign-extended when XLEN = 64.
  - funct3 110 LWU: word at off, zero-extended; XLEN = 64 only.
  - funct3 011 LD: full raw data; XLEN = 64 only.
  - Any other funct3: raw mem_rdata unchanged.
- wbsel = 2 with in_is_load = 0: rf_wdata = 0 and the commit proceeds normally.
- rst asserted in any state: next cycle is IDLE with outputs at reset values. The pending entry is dropped without a commit. A late mem_rvalid after reset is ignored.

Optional Feature:
- Macro WRITEBACK_MEM_TIMEOUT_EN.
- Defined:
  - An 8..32-bit counter clears on entry to WAIT_MEM and increments each WAIT_MEM cycle without mem_rvalid.
  - When it reaches TIMEOUT_CYCLES, mem_timeout pulses for one cycle, the FSM goes to COMMIT with load data = 0, and the commit proceeds.
  - mem_rvalid in the same cycle as the timeout wins: normal data, no mem_timeout.
- Not defined: no counter, mem_timeout = 0, and WAIT_MEM waits indefinitely.

Test Plan:
- Reset: hold rst 2 cycles during WAIT_MEM, then pulse mem_rvalid -> no commit_valid; in_ready = 1; rf_wen = 0.
- Back-to-back ALU ops: rd = 5, 6, 7 accepted on consecutive cycles with alu_result 0x11, 0x22, 0x33 and wbsel 0 -> commits on the 3 following consecutive cycles with rf_wdata 0x11 / 0x22 / 0x33; in_ready stays 1.
- rd = 0 with wen = 1, wbsel 1, snpc 0x80000004 -> commit_valid = 1, rf_wen = 0.
- LB with alu_result 0x80000003, mem_rdata 0x80FF7F01, mem_rvalid 4 cycles later -> in_ready = 0 for those 4 cycles; rf_wdata 0xFFFFFF80.
- LHU at offset 2 with mem_rdata 0xBEEF1234 -> rf_wdata 0x0000BEEF. LH at offset 2 with the same data -> 0xFFFFBEEF.
- WRITEBACK_MEM_TIMEOUT_EN with TIMEOUT_CYCLES = 4 and no mem_rvalid -> mem_timeout pulses once; commit with rf_wdata 0. Repeat with mem_rvalid on the timeout cycle -> no mem_timeout, normal data.
